time_display: RTL and testbench

// Consumer end of the Time block's hours/mins/secs/mode interface. Converts the

---
 rtl/time_display.sv | 137 +++++++++++++
 tb/tb_time_display.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/time_display.sv
// time_display: converts binary hours/mins/secs into six multiplexed 7-segment
// digits (HH.MM.SS), scanning one digit at a time and blinking the field chosen
// by mode. All outputs are active-low and registered.
module time_display #(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic [1:0] mode,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;
    logic [1:0]         mode_q;

    logic               scan_wrap;
    logic               blink_wrap;
    logic [1:0]         field_sel;
    logic [5:0]         field_val;
    logic               field_bad;
    logic [3:0]         digit_val;
    logic               blank;
    logic [5:0]         an_nxt;
    logic [6:0]         seg_nxt;
    logic               dp_nxt;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // Digit slot timer: each digit stays lit for SCAN_DIV cycles, cycling 0..5.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blink phase; a mode change restarts it visible so the new field shows first.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            mode_q       <= 2'b00;
        end else if (mode != mode_q) begin
            mode_q       <= mode;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BLINK_W'(1);
        end
    end

    // Select field and digit for the current slot and build the next output pattern.
    always_comb begin
        field_sel = digit_idx[2:1];
        field_val = secs;
        field_bad = 1'b0;
        case (field_sel)
            2'd0:    begin field_val = secs;  field_bad = (secs  > 6'd59); end
            2'd1:    begin field_val = mins;  field_bad = (mins  > 6'd59); end
            default: begin field_val = hours; field_bad = (hours > 6'd23); end
        endcase

        if (digit_idx[0])
            digit_val = 4'(field_val / 6'd10);
        else
            digit_val = 4'(field_val % 6'd10);

        // mode 01/10/11 selects field 0/1/2, i.e. field index = mode - 1
        blank = blink_hidden && (mode_q != 2'b00) && (field_sel == (mode_q - 2'd1));

        an_nxt  = ~(6'd1 << digit_idx);
        seg_nxt = field_bad ? SEG_DASH : seg_encode(digit_val);
        dp_nxt  = ~((digit_idx == 3'd2) || (digit_idx == 3'd4));

        if (blank) begin
            an_nxt  = 6'h3F;
            seg_nxt = SEG_OFF;
            dp_nxt  = 1'b1;
        end
    end

    // Registered display outputs, dark during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 6'h3F;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Randomised bench for time_display with a time-based reference model:
// the expected digit and blink phase come from counts of elapsed cycles.
module tb_time_display;

    localparam int SCAN  = 4;
    localparam int BLINK = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hours, mins, secs;
    logic [1:0] mode;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // reference state: cycles since reset release, cycles since blink restart, stored mode
    int slots = 0;
    int since = 0;
    int smode = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    time_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk   (clk),
        .reset (reset),
        .hours (hours),
        .mins  (mins),
        .secs  (secs),
        .mode  (mode),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: predict outputs from current inputs and model, clock, then compare.
    task automatic step();
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int d, f, val, lim;
        bit hidden;
        if (reset) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            slots = 0; since = 0; smode = 0;
        end else begin
            d   = (slots / SCAN) % 6;
            f   = d / 2;
            val = (f == 0) ? int'(secs) : (f == 1) ? int'(mins) : int'(hours);
            lim = (f == 2) ? 24 : 60;
            if (val >= lim)      e_seg = 7'h3F;
            else if (d % 2 == 0) e_seg = seg_tab[val % 10];
            else                 e_seg = seg_tab[val / 10];
            e_an = ~(6'd1 << d);
            e_dp = (d == 2 || d == 4) ? 1'b0 : 1'b1;
            hidden = ((since / BLINK) % 2) == 1;
            if (hidden && smode != 0 && smode - 1 == f) begin
                e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            end
            slots++;
            if (int'(mode) != smode) begin
                smode = int'(mode);
                since = 0;
            end else begin
                since++;
            end
        end
        @(posedge clk);
        #1;
        chk("an",  32'(an),  32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp",  32'(dp),  32'(e_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; hours = 6'd0; mins = 6'd0; secs = 6'd0; mode = 2'b00;
        #1;
        run(3);
        reset = 1'b0;
        run(8);

        // 23:45:07 running, then mins blinking
        hours = 6'd23; mins = 6'd45; secs = 6'd7;
        run(30);
        mode = 2'b10;
        run(40);

        // out-of-range seconds
        mode = 2'b00; hours = 6'd0; mins = 6'd0; secs = 6'd60;
        run(30);

        // switch mins -> hours while hidden
        secs = 6'd7; mins = 6'd45; hours = 6'd23; mode = 2'b10;
        run(11);
        mode = 2'b11;
        run(34);

        // reset pulse while digit 3 is lit
        while (((slots / SCAN) % 6) != 3) step();
        step();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(12);

        // randomised traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                hours = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(24, 63)) : 6'($urandom_range(0, 23));
                mins  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
                secs  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
